// File: rtl/osd_io_pkg.sv
// Shared types for the OSD I/O bridge: FSM states, FIFO entry layout, word width.
package osd_io_pkg;

  localparam int OSD_IO_W = 16;
  localparam int CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STB_H,
    STB_L,
    GAP,
    DRAIN
  } osd_io_state_e;

  typedef struct packed {
    logic                last;
    logic [OSD_IO_W-1:0] data;
  } osd_io_entry_t;

endpackage

// File: rtl/osd_io_fifo.sv
// Entry FIFO for the OSD bridge. The read register only loads on pop, so it can
// drive io_din directly; drop advances the head without touching that register.
module osd_io_fifo
  import osd_io_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  osd_io_entry_t push_entry_i,
  input  logic          pop_i,
  input  logic          drop_i,
  output osd_io_entry_t rd_entry_o,
  output logic          head_last_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          empty_nxt_o
);

  localparam int AW = $clog2(DEPTH);

  osd_io_entry_t mem_q [DEPTH];
  osd_io_entry_t rd_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_adv, do_load;

  assign full_o      = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign do_push     = push_i & ~full_o;
  assign do_adv      = (pop_i | drop_i) & ~empty_o;
  assign do_load     = pop_i & ~empty_o;
  assign cnt_d       = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_adv);
  assign empty_nxt_o = (cnt_d == '0);
  assign head_last_o = mem_q[rptr_q].last;
  assign rd_entry_o  = rd_q;

  // Storage is not reset; flushing the pointers is enough to empty it.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= push_entry_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_adv)  rptr_q <= rptr_q + AW'(1);
      if (do_load) rd_q   <= mem_q[rptr_q];
    end
  end

endmodule

// File: rtl/osd_io_bridge.sv
// Host stream to OSD io_osd/io_strobe/io_din serialiser with strobe pacing.
// Define OSD_IO_BRIDGE_WATCHDOG_EN to abort stalled transactions after TIMEOUT cycles.
module osd_io_bridge
  import osd_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SETUP_CYC  = 2,
  parameter int STB_HI     = 2,
  parameter int STB_LO     = 2,
  parameter int GAP_CYC    = 3,
  parameter int TIMEOUT    = 1024
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [OSD_IO_W-1:0] wr_data,
  input  logic                wr_last,
  output logic                io_osd,
  output logic                io_strobe,
  output logic [OSD_IO_W-1:0] io_din,
  output logic                busy,
  output logic                wd_err,
  output osd_io_state_e       dbg_state
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SETUP_CYC < 1 ||
      STB_HI < 1 || STB_LO < 1 || GAP_CYC < 1 || TIMEOUT < 1) begin : g_param_err
    $error("osd_io_bridge: illegal parameter value");
  end

  localparam logic [CNT_W-1:0] SETUP_T = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HI_T    = CNT_W'(STB_HI - 1);
  localparam logic [CNT_W-1:0] LO_T    = CNT_W'(STB_LO - 1);
  localparam logic [CNT_W-1:0] GAP_T   = CNT_W'(GAP_CYC - 1);

  osd_io_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, term;
  logic             cnt_done;
  logic             push, pop, drop, full, empty, empty_nxt, head_last;
  logic             osd_q, osd_d, stb_q, stb_d, busy_q, busy_d;
  logic             wd_hit;
  osd_io_entry_t    wr_entry, rd_entry;

  assign wr_entry  = '{last: wr_last, data: wr_data};
  assign push      = wr_valid & ~full;
  assign wr_ready  = ~full;
  assign io_osd    = osd_q;
  assign io_strobe = stb_q;
  assign io_din    = rd_entry.data;
  assign busy      = busy_q;
  assign dbg_state = state_q;

  osd_io_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_sys),
    .rst_i       (reset),
    .push_i      (push),
    .push_entry_i(wr_entry),
    .pop_i       (pop),
    .drop_i      (drop),
    .rd_entry_o  (rd_entry),
    .head_last_o (head_last),
    .full_o      (full),
    .empty_o     (empty),
    .empty_nxt_o (empty_nxt)
  );

`ifdef OSD_IO_BRIDGE_WATCHDOG_EN
  logic [31:0] wd_cnt_q;
  logic        wd_run, wd_err_q;

  // Only a stall mid-transaction counts; waiting out STB_LO after a last word is normal.
  assign wd_run = (state_q == STB_L) && empty && !rd_entry.last;
  assign wd_hit = wd_run && (wd_cnt_q == 32'(TIMEOUT - 1));
  assign wd_err = wd_err_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_run ? wd_cnt_q + 32'd1 : '0;
      if (wd_hit) wd_err_q <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign wd_err = 1'b0;
`endif

  always_comb begin
    case (state_q)
      SETUP:   term = SETUP_T;
      STB_H:   term = HI_T;
      STB_L:   term = LO_T;
      GAP:     term = GAP_T;
      default: term = '0;
    endcase
  end
  assign cnt_done = (cnt_q == term);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE:  if (!empty) state_d = SETUP;
      SETUP: if (cnt_done) begin
        pop     = 1'b1;
        state_d = STB_H;
      end
      STB_H: if (cnt_done) state_d = STB_L;
      STB_L: if (cnt_done) begin
        if (rd_entry.last) begin
          state_d = GAP;
        end else if (!empty) begin
          pop     = 1'b1;
          state_d = STB_H;
        end
      end
      GAP:   if (cnt_done) state_d = IDLE;
      DRAIN: if (!empty) begin
        drop = 1'b1;
        if (head_last) state_d = GAP;
      end
      default: state_d = IDLE;
    endcase
    if (wd_hit) begin
      state_d = DRAIN;
      pop     = 1'b0;
    end
  end

  // Counters reload on every state change and hold at their terminal value.
  always_comb begin
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_done)      cnt_d = cnt_q;
    else                    cnt_d = cnt_q + CNT_W'(1);
    osd_d  = (state_d == SETUP) || (state_d == STB_H) || (state_d == STB_L);
    stb_d  = (state_d == STB_H);
    busy_d = !empty_nxt || (state_d != IDLE);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      osd_q   <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      osd_q   <= osd_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_osd_io_bridge.sv
// Randomised bench for osd_io_bridge: an edge-timed frame model predicts every
// strobe's word and edge, io_osd framing, wr_ready and busy.
module tb_osd_io_bridge;
  import osd_io_pkg::*;

  localparam int DEPTH = 16;
  localparam int SETUP = 2;
  localparam int HI    = 2;
  localparam int LO    = 2;
  localparam int GAP   = 3;
  localparam int TMO   = 16;
  localparam int EW    = 49;  // {accept_edge[31:0], last, data[15:0]}

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_last = 1'b0;
  logic [15:0]   wr_data = '0;
  logic          wr_ready, io_osd, io_strobe, busy, wd_err;
  logic [15:0]   io_din;
  osd_io_state_e dbg_state;

  int n_vec = 0, n_err = 0;
  int edge_cnt = 0, occ = 0, n_rise = 0;
  int cur_rise = 0, cur_fall = 0, osd_rise_e = 0, words_in_frame = 0;
  int last_sf = -1000;
  bit cur_last = 1'b0, frame_open = 1'b0, prev_osd = 1'b0, prev_stb = 1'b0;
  bit mon_en = 1'b1;
  logic [EW-1:0] exp_q[$];

  osd_io_bridge #(
    .FIFO_DEPTH(DEPTH), .SETUP_CYC(SETUP), .STB_HI(HI), .STB_LO(LO),
    .GAP_CYC(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk_sys  (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .io_osd   (io_osd),
    .io_strobe(io_strobe),
    .io_din   (io_din),
    .busy     (busy),
    .wd_err   (wd_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Outputs are sampled on the falling edge; edge_cnt then names the rising
  // edge at which they last changed. An accept seen now lands on edge_cnt+1.
  always @(negedge clk) begin : mon
    logic [EW-1:0] ent;
    int e_exp;
    if (reset) begin
      exp_q.delete();
      occ        = 0;
      frame_open = 1'b0;
      cur_last   = 1'b0;
      last_sf    = -1000;
      prev_osd   = 1'b0;
      prev_stb   = 1'b0;
    end else if (mon_en) begin
      if (io_osd && !prev_osd) begin
        if (exp_q.size() == 0) chk("osd_rise_without_data", 32'd1, 32'd0);
        else begin
          e_exp = imax(int'(exp_q[0][48:17]), last_sf + LO + GAP) + 1;
          chk("osd_rise_edge", edge_cnt, e_exp);
        end
        osd_rise_e     = edge_cnt;
        words_in_frame = 0;
      end
      if (io_strobe && !prev_stb) begin
        n_rise++;
        chk("stb_while_osd", {31'd0, io_osd}, 32'd1);
        if (exp_q.size() == 0) chk("stb_extra", 32'd1, 32'd0);
        else begin
          ent = exp_q.pop_front();
          occ--;
          chk("din", {16'd0, io_din}, {16'd0, ent[15:0]});
          if (words_in_frame == 0) e_exp = osd_rise_e + SETUP;
          else e_exp = imax(cur_rise + HI + LO, int'(ent[48:17]) + 1);
          chk("stb_rise_edge", edge_cnt, e_exp);
          cur_rise   = edge_cnt;
          cur_last   = ent[16];
          frame_open = 1'b1;
          words_in_frame++;
        end
      end
      if (!io_strobe && prev_stb) begin
        chk("stb_high_len", edge_cnt - cur_rise, HI);
        cur_fall = edge_cnt;
        if (cur_last) begin
          last_sf    = edge_cnt;
          frame_open = 1'b0;
        end
      end
      if (!io_osd && prev_osd)
        chk("osd_fall_edge", edge_cnt, frame_open ? 32'hFFFF_FFFF : 32'(last_sf + LO));
      chk("wr_ready", {31'd0, wr_ready}, {31'd0, occ < DEPTH});
      chk("busy", {31'd0, busy},
          {31'd0, (occ > 0) || frame_open || (edge_cnt < last_sf + LO + GAP)});
      chk("wd_err", {31'd0, wd_err}, 32'd0);
      if (wr_valid && wr_ready) begin
        exp_q.push_back({32'(edge_cnt + 1), wr_last, wr_data});
        occ++;
      end
      prev_osd = io_osd;
      prev_stb = io_strobe;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; leaves wr_valid high so words can stream.
  task automatic push_word(input logic [15:0] d, input logic l);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = l;
    @(negedge clk);
    while (!wr_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("push_stall", {31'd0, n < 3000}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int c);
    wr_valid = 1'b0;
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    wr_valid = 1'b0;
    while ((exp_q.size() != 0 || frame_open || edge_cnt < last_sf + LO + GAP + 2) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, n < 5000}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_osd"},   {31'd0, io_osd},    32'd0);
    chk({tag, "_stb"},   {31'd0, io_strobe}, 32'd0);
    chk({tag, "_din"},   {16'd0, io_din},    32'd0);
    chk({tag, "_busy"},  {31'd0, busy},      32'd0);
    chk({tag, "_wderr"}, {31'd0, wd_err},    32'd0);
    chk({tag, "_ready"}, {31'd0, wr_ready},  32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, n, len;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // Command-only transaction: exactly one strobe.
    push_word(16'h0041, 1'b1);
    wait_idle();

    // Long write: 0x0020 then 256 data bytes, streamed with wr_valid held.
    push_word(16'h0020, 1'b0);
    for (int i = 0; i < 256; i++) push_word(16'($urandom_range(0, 255)), 1'b1 ? (i == 255) : 1'b0);
    wait_idle();

    // Burst of 20 words against a 16-deep FIFO.
    push_word(16'h0023, 1'b0);
    for (int i = 1; i < 20; i++) push_word(16'($urandom), i == 19);
    wait_idle();

    // Command, then data 50 cycles later: frame held open with strobe low.
    push_word(16'h0021, 1'b0);
    wr_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("hold_osd", {31'd0, io_osd}, 32'd1);
    chk("hold_stb", {31'd0, io_strobe}, 32'd0);
    @(posedge clk);
    #1;
    idle_cycles(20);
    push_word(16'hBEEF, 1'b1);
    wait_idle();

    // Random transactions with random inter-word and inter-transaction gaps.
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 8);
      push_word(16'h0020 | 16'($urandom_range(0, 15)), len == 1);
      for (int i = 1; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 6));
        push_word(16'($urandom), i == len - 1);
      end
      idle_cycles($urandom_range(0, 12));
    end
    wait_idle();

    // Asynchronous reset during the third strobe of a write.
    base = n_rise;
    push_word(16'h0022, 1'b0);
    for (int i = 0; i < 6; i++) push_word(16'($urandom), i == 5);
    wr_valid = 1'b0;
    n = 0;
    while (n_rise < base + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_stb3", {31'd0, n_rise >= base + 3}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    push_word(16'h0041, 1'b1);
    wait_idle();

`ifdef OSD_IO_BRIDGE_WATCHDOG_EN
    // Stalled transaction: watchdog aborts the frame and drains to the next last word.
    begin
      int seen;
      mon_en = 1'b0;
      push_word(16'h0042, 1'b0);
      wr_valid = 1'b0;
      repeat (SETUP + HI + LO + TMO + 6) @(negedge clk);
      chk("wd_err_set", {31'd0, wd_err}, 32'd1);
      chk("wd_osd_low", {31'd0, io_osd}, 32'd0);
      @(posedge clk);
      #1;
      seen = 0;
      push_word(16'h1111, 1'b0);
      push_word(16'h2222, 1'b1);
      wr_valid = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (io_strobe || io_osd) seen++;
      end
      chk("wd_discard", seen, 32'd0);
      chk("wd_busy", {31'd0, busy}, 32'd0);
      chk("wd_sticky", {31'd0, wd_err}, 32'd1);
      @(posedge clk);
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      push_word(16'h0041, 1'b1);
      wait_idle();
    end
`endif

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
